mcu0_seq_ctrl: RTL and testbench
================================

// Module: mcu0_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the mcu0 datapath (PC, IR, A, SW, ALU) sharing ONE memory port between fetch and data access.
//  Replaces the single-cycle decoder: walks FETCH/EXEC/MEM per instruction, drives all register write strobes and mux selects,
//  and handshakes with a variable-latency memory. Sits beside the datapath inside mcu; memory is external to it.
// PARAMETERS
//  CNT_W     16  width of retired-instruction counter
//  OP_W      4   opcode width (ir[15:12])
//  ALUOP_W   4   ALU op code width
// PORTS
//  clock     in   1        single clock, all state on posedge
//  reset_n   in   1        reset, synchronous, active-low
//  start     in   1        leave IDLE and begin fetching at current PC
//  stop      in   1        halt at next instruction boundary
//  op        in   OP_W     opcode from IR (ir[15:12]), valid from EXEC onward
//  z         in   1        SW zero/equal flag (SW[14])
//  mem_ack   in   1        memory transfer done this cycle (1-cycle pulse per transfer)
//  mem_req   out  1        memory request
//  mem_we    out  1        1=write A to mem[C], 0=read
//  addr_sel  out  1        memory address: 0=PC, 1=C (ir[11:0])
//  ir_w      out  1        load IR from memory read data
//  pc_w      out  1        load PC
//  pc_sel    out  1        PC source: 0=PC+2, 1=C
//  a_w       out  1        load A from ALU output
//  sw_w      out  1        load SW from ALU output
//  alu_op    out  ALUOP_W  ZERO=0, ADD=1, CMP=E, APASS=F
//  busy      out  1        state != IDLE
//  retired   out  CNT_W    completed instruction count, wraps modulo 2^CNT_W
//  trap      out  1        illegal opcode trap (tied 0 without MCU0_SEQ_TRAP_EN)
// BEHAVIOUR
//  States IDLE, FETCH, EXEC, MEM (+TRAP). Strobes are combinational from state/op/mem_ack; default all 0, alu_op=ZERO.
//  Reset (reset_n=0 at posedge): state=IDLE, retired=0, trap=0; all strobes 0 from that edge, even mid-handshake (request abandoned).
//  IDLE: start=1 -> FETCH. start ignored in any other state.
//  FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ack: ir_w=1, pc_w=1, pc_sel=0 same cycle -> EXEC.
//  EXEC by op: LD(0)/ADD(1)/CMP(4) -> MEM read; ST(3) -> MEM write; JMP(2): pc_w=1, pc_sel=1, retire;
//   JEQ(5): pc_w=pc_sel=z, retire; other op: see CONFIGURATION.
//  MEM: mem_req=1, addr_sel=1, mem_we=(op==ST). On mem_ack: LD a_w=1,alu_op=APASS; ADD a_w=1,alu_op=ADD;
//   CMP sw_w=1,alu_op=CMP; ST no strobe; retire.
//  Handshake: mem_req, mem_we, addr_sel held stable until the mem_ack cycle; ack in the request's first cycle = zero wait.
//   mem_ack outside FETCH/MEM ignored. Back-to-back requests (MEM ack -> FETCH req next cycle) allowed.
//  Retire: retired+=1 on the retiring edge; next state FETCH, or IDLE if stop=1 that cycle. stop never aborts an instruction.
//  Latency: JMP/JEQ 2 cycles, memory ops 3 cycles, plus wait cycles of each memory transfer.
// CONFIGURATION
//  MCU0_SEQ_TRAP_EN defined: illegal op in EXEC -> TRAP; trap=1, busy=1, no strobes, no retire; exit only via reset.
//  Not defined: illegal op is a NOP: retires in EXEC, no strobes, -> FETCH/IDLE; trap tied 0; TRAP state absent.
// STRUCTURE
//  Package mcu0_pkg: opcode constants LD..JEQ, ALU op constants ZERO/ADD/CMP/APASS, state enum, shared with datapath+ALU.
//  Sub-module mcu0_op_decode (combinational): op -> {is_mem, is_st, is_jmp, is_jeq, legal, mem_aluop, mem_aw, mem_sww}.
// TESTING
//  Reset: reset_n=0 2 cycles with start=1 -> IDLE, busy=0, retired=0, all strobes 0.
//  LD, zero-wait ack: cyc1 FETCH ir_w=pc_w=1 pc_sel=0; cyc2 EXEC; cyc3 MEM a_w=1 alu_op=F; retired=1.
//  ST, ack after 3 waits: mem_req=mem_we=addr_sel=1 held 4 cycles, no a_w/sw_w, retired +1 once.
//  JEQ z=1 -> EXEC pc_w=1 pc_sel=1; JEQ z=0 -> pc_w=0; JMP -> pc_w=1 pc_sel=1; each retires, no mem_req in EXEC.
//  ADD with stop=1 raised mid-MEM wait -> a_w=1 alu_op=1 on ack, then IDLE, busy=0; reset_n=0 in FETCH wait -> mem_req=0 next cycle.
//  op=9: with MCU0_SEQ_TRAP_EN -> trap=1 held, retired unchanged, start ignored; without -> NOP, retired+1, FETCH.

Source files
------------

// File: rtl/mcu0_pkg.sv
// Shared mcu0 constants: opcodes, ALU op codes and the sequencer state encoding.
// The TRAP state exists only when MCU0_SEQ_TRAP_EN is defined.
package mcu0_pkg;

    localparam int OP_W    = 4;
    localparam int ALUOP_W = 4;

    localparam logic [OP_W-1:0] OP_LD  = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W-1:0] OP_JMP = 4'd2;
    localparam logic [OP_W-1:0] OP_ST  = 4'd3;
    localparam logic [OP_W-1:0] OP_CMP = 4'd4;
    localparam logic [OP_W-1:0] OP_JEQ = 4'd5;

    localparam logic [ALUOP_W-1:0] ALU_ZERO  = 4'h0;
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'h1;
    localparam logic [ALUOP_W-1:0] ALU_CMP   = 4'hE;
    localparam logic [ALUOP_W-1:0] ALU_APASS = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM
`ifdef MCU0_SEQ_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

endpackage

// File: rtl/mcu0_op_decode.sv
// Combinational opcode classifier for the mcu0 sequencer.
import mcu0_pkg::*;

module mcu0_op_decode (
    input  logic [OP_W-1:0]    op,
    output logic               is_mem,
    output logic               is_st,
    output logic               is_jmp,
    output logic               is_jeq,
    output logic               legal,
    output logic [ALUOP_W-1:0] mem_aluop,
    output logic               mem_aw,
    output logic               mem_sww
);

    always_comb begin
        is_mem    = 1'b0;
        is_st     = 1'b0;
        is_jmp    = 1'b0;
        is_jeq    = 1'b0;
        legal     = 1'b1;
        mem_aluop = ALU_ZERO;
        mem_aw    = 1'b0;
        mem_sww   = 1'b0;
        case (op)
            OP_LD: begin
                is_mem    = 1'b1;
                mem_aluop = ALU_APASS;
                mem_aw    = 1'b1;
            end
            OP_ADD: begin
                is_mem    = 1'b1;
                mem_aluop = ALU_ADD;
                mem_aw    = 1'b1;
            end
            OP_CMP: begin
                is_mem    = 1'b1;
                mem_aluop = ALU_CMP;
                mem_sww   = 1'b1;
            end
            OP_ST: begin
                is_mem = 1'b1;
                is_st  = 1'b1;
            end
            OP_JMP:  is_jmp = 1'b1;
            OP_JEQ:  is_jeq = 1'b1;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcu0_seq_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM sequencer sharing one memory port with variable-latency handshake.
// Optional illegal-opcode trap state enabled by MCU0_SEQ_TRAP_EN.
import mcu0_pkg::*;

module mcu0_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [OP_W-1:0]    op,
    input  logic               z,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_w,
    output logic               pc_w,
    output logic               pc_sel,
    output logic               a_w,
    output logic               sw_w,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               busy,
    output logic [CNT_W-1:0]   retired,
    output logic               trap
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_retired;
    logic               w_is_mem;
    logic               w_is_st;
    logic               w_is_jmp;
    logic               w_is_jeq;
    logic               w_legal;
    logic [ALUOP_W-1:0] w_mem_aluop;
    logic               w_mem_aw;
    logic               w_mem_sww;
    logic               w_retire;

    mcu0_op_decode u_decode (
        .op        (op),
        .is_mem    (w_is_mem),
        .is_st     (w_is_st),
        .is_jmp    (w_is_jmp),
        .is_jeq    (w_is_jeq),
        .legal     (w_legal),
        .mem_aluop (w_mem_aluop),
        .mem_aw    (w_mem_aw),
        .mem_sww   (w_mem_sww)
    );

    // Jumps (and, without the trap, illegal NOPs) finish in EXEC; memory ops finish on their ack.
`ifdef MCU0_SEQ_TRAP_EN
    assign w_retire = ((r_state == ST_EXEC) && !w_is_mem && w_legal) ||
                      ((r_state == ST_MEM) && mem_ack);
`else
    assign w_retire = ((r_state == ST_EXEC) && !w_is_mem) ||
                      ((r_state == ST_MEM) && mem_ack);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
            r_state   <= stop ? ST_IDLE : ST_FETCH;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) r_state <= ST_FETCH;
                ST_FETCH: if (mem_ack) r_state <= ST_EXEC;
`ifdef MCU0_SEQ_TRAP_EN
                ST_EXEC:  r_state <= w_is_mem ? ST_MEM : ST_TRAP;
                ST_TRAP:  r_state <= ST_TRAP;
`else
                ST_EXEC:  r_state <= ST_MEM;
`endif
                ST_MEM:   r_state <= ST_MEM;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes follow the current state; request signals stay flat until the ack cycle.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        pc_sel   = 1'b0;
        a_w      = 1'b0;
        sw_w     = 1'b0;
        alu_op   = ALU_ZERO;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_w    = mem_ack;
                pc_w    = mem_ack;
            end
            ST_EXEC: begin
                if (w_legal && w_is_jmp) begin
                    pc_w   = 1'b1;
                    pc_sel = 1'b1;
                end else if (w_legal && w_is_jeq) begin
                    pc_w   = z;
                    pc_sel = z;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_is_st;
                if (mem_ack) begin
                    a_w    = w_mem_aw;
                    sw_w   = w_mem_sww;
                    alu_op = w_mem_aluop;
                end
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != ST_IDLE);
    assign retired = r_retired;

`ifdef MCU0_SEQ_TRAP_EN
    logic r_trap;

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_trap <= 1'b0;
        else if ((r_state == ST_EXEC) && !w_legal)
            r_trap <= 1'b1;
    end

    assign trap = r_trap;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_mcu0_seq_ctrl.sv
// Self-checking bench for mcu0_seq_ctrl: directed scenarios plus a random instruction stream
// checked cycle by cycle against a per-instruction transaction model.
module tb_mcu0_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [3:0]  op;
    logic        z;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_w;
    logic        pc_w;
    logic        pc_sel;
    logic        a_w;
    logic        sw_w;
    logic [3:0]  alu_op;
    logic        busy;
    logic [15:0] retired;
    logic        trap;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] modelRetired = '0;

    always #5 clock = ~clock;

    mcu0_seq_ctrl dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .op       (op),
        .z        (z),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .ir_w     (ir_w),
        .pc_w     (pc_w),
        .pc_sel   (pc_sel),
        .a_w      (a_w),
        .sw_w     (sw_w),
        .alu_op   (alu_op),
        .busy     (busy),
        .retired  (retired),
        .trap     (trap)
    );

`ifdef MCU0_SEQ_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    // Observed bus: {mem_req, mem_we, addr_sel, ir_w, pc_w, pc_sel, a_w, sw_w, alu_op, busy, trap}
    function automatic logic [13:0] observed();
        return {mem_req, mem_we, addr_sel, ir_w, pc_w, pc_sel, a_w, sw_w, alu_op, busy, trap};
    endfunction

    function automatic bit isMemOp(input logic [3:0] o);
        return (o == 4'd0) || (o == 4'd1) || (o == 4'd3) || (o == 4'd4);
    endfunction

    function automatic bit isLegal(input logic [3:0] o);
        return o <= 4'd5;
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Enter from IDLE: one cycle with start raised, then the DUT should be fetching.
    task automatic applyStimulus(input string tag);
        logic [13:0] exp;
        start   = 1'b1;
        stop    = 1'b0;
        mem_ack = 1'($urandom);
        op      = 4'($urandom);
        #1;
        exp = '0;
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL %s idle-start: got=%b exp=%b", tag, observed(), exp);
        end
        nextCycle();
        start = 1'b0;
    endtask

    // One complete instruction from its first FETCH cycle, with fw/mw wait cycles before each ack.
    task automatic checkOutput(input logic [3:0] iop, input logic iz, input int fw, input int mw,
                               input logic istop, input string tag);
        logic [13:0] exp;
        logic        pcw;
        logic        aw;
        logic        sww;
        logic [3:0]  alu;
        logic        ack;
        for (int i = 0; i <= fw; i++) begin
            op      = 4'($urandom);
            z       = 1'($urandom);
            stop    = 1'($urandom);
            start   = 1'($urandom);
            mem_ack = (i == fw);
            #1;
            exp = {1'b1, 1'b0, 1'b0, mem_ack, mem_ack, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("[TB] FAIL %s fetch%0d: got=%b exp=%b", tag, i, observed(), exp);
            end
            checks++;
            if (retired !== modelRetired) begin
                errors++;
                $display("[TB] FAIL %s fetch-retired: got=%0d exp=%0d", tag, retired, modelRetired);
            end
            nextCycle();
        end
        op      = iop;
        z       = iz;
        mem_ack = 1'($urandom);
        start   = 1'($urandom);
        stop    = isMemOp(iop) ? 1'($urandom) : istop;
        #1;
        pcw = (iop == 4'd2) || ((iop == 4'd5) && iz);
        exp = {3'b000, 1'b0, pcw, pcw, 2'b00, 4'h0, 1'b1, 1'b0};
        checks++;
        if (observed() !== exp) begin
            errors++;
            $display("[TB] FAIL %s exec op=%0d: got=%b exp=%b", tag, iop, observed(), exp);
        end
        nextCycle();
        if (!isMemOp(iop)) begin
            if (!isLegal(iop) && TrapEn) begin
                checks++;
                if ({busy, trap, retired} !== {2'b11, modelRetired}) begin
                    errors++;
                    $display("[TB] FAIL %s trap-entry: got busy=%b trap=%b ret=%0d exp 1 1 %0d",
                             tag, busy, trap, retired, modelRetired);
                end
                return;
            end
            modelRetired++;
        end else begin
            for (int j = 0; j <= mw; j++) begin
                op      = iop;
                z       = 1'($urandom);
                start   = 1'($urandom);
                ack     = (j == mw);
                mem_ack = ack;
                stop    = ack ? istop : 1'($urandom);
                #1;
                aw  = ack && ((iop == 4'd0) || (iop == 4'd1));
                sww = ack && (iop == 4'd4);
                alu = !ack ? 4'h0 : (iop == 4'd0) ? 4'hF : (iop == 4'd1) ? 4'h1 :
                      (iop == 4'd4) ? 4'hE : 4'h0;
                exp = {1'b1, (iop == 4'd3), 1'b1, 3'b000, aw, sww, alu, 1'b1, 1'b0};
                checks++;
                if (observed() !== exp) begin
                    errors++;
                    $display("[TB] FAIL %s mem%0d op=%0d: got=%b exp=%b", tag, j, iop, observed(), exp);
                end
                checks++;
                if (retired !== modelRetired) begin
                    errors++;
                    $display("[TB] FAIL %s mem-retired: got=%0d exp=%0d", tag, retired, modelRetired);
                end
                nextCycle();
            end
            modelRetired++;
        end
        checks++;
        if ({retired, busy} !== {modelRetired, ~istop}) begin
            errors++;
            $display("[TB] FAIL %s retire: got ret=%0d busy=%b exp ret=%0d busy=%b",
                     tag, retired, busy, modelRetired, ~istop);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        stop    = 1'b0;
        mem_ack = 1'b0;
        op      = 4'd0;
        z       = 1'b0;
        nextCycle();
        nextCycle();
        checks++;
        if ({observed(), retired} !== {14'b0, 16'd0}) begin
            errors++;
            $display("[TB] FAIL reset: got=%b ret=%0d exp all zero", observed(), retired);
        end
        modelRetired = '0;
        reset_n = 1'b1;
        start   = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset-idle: busy got=%b exp=0", busy);
        end
        nextCycle();
    endtask

    task automatic test_ld_zero_wait();
        applyStimulus("ld");
        checkOutput(4'd0, 1'b0, 0, 0, 1'b1, "ld");
    endtask

    task automatic test_st_waits();
        applyStimulus("st");
        checkOutput(4'd3, 1'b1, 1, 3, 1'b1, "st");
    endtask

    task automatic test_jumps();
        applyStimulus("jmp");
        checkOutput(4'd5, 1'b1, 1, 0, 1'b0, "jeq-z1");
        checkOutput(4'd5, 1'b0, 0, 0, 1'b0, "jeq-z0");
        checkOutput(4'd2, 1'b0, 2, 0, 1'b1, "jmp");
    endtask

    task automatic test_back_to_back();
        applyStimulus("b2b");
        checkOutput(4'd4, 1'b0, 0, 0, 1'b0, "b2b-cmp");
        checkOutput(4'd1, 1'b0, 0, 0, 1'b0, "b2b-add");
        checkOutput(4'd1, 1'b0, 0, 3, 1'b1, "add-stop");
    endtask

    task automatic test_reset_mid_fetch();
        applyStimulus("rstfetch");
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstfetch-req: got=%b exp=1", mem_req);
        end
        reset_n = 1'b0;
        nextCycle();
        checks++;
        if ({mem_req, busy, retired} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL rstfetch-drop: got req=%b busy=%b ret=%0d exp 0 0 0", mem_req, busy, retired);
        end
        modelRetired = '0;
        reset_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_illegal();
        logic [13:0] exp;
        applyStimulus("illegal");
        checkOutput(4'd9, 1'b0, 0, 0, 1'b0, "illegal");
        if (TrapEn) begin
            for (int k = 0; k < 4; k++) begin
                start   = 1'b1;
                mem_ack = 1'($urandom);
                #1;
                exp = {12'b0, 1'b1, 1'b1};
                checks++;
                if ({observed(), retired} !== {exp, modelRetired}) begin
                    errors++;
                    $display("[TB] FAIL trap-hold%0d: got=%b ret=%0d exp=%b ret=%0d",
                             k, observed(), retired, exp, modelRetired);
                end
                nextCycle();
            end
            start = 1'b0;
            test_reset();
        end else begin
            checkOutput(4'd2, 1'b0, 0, 0, 1'b1, "after-nop");
        end
    endtask

    task automatic test_random();
        logic [3:0] rop;
        logic       rstop;
        applyStimulus("rand");
        for (int n = 0; n < 60; n++) begin
            if (!TrapEn && ($urandom_range(0, 7) == 0))
                rop = 4'($urandom_range(6, 15));
            else
                rop = 4'($urandom_range(0, 5));
            rstop = ($urandom_range(0, 4) == 0) || (n == 59);
            checkOutput(rop, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rstop, "rand");
            if (rstop && n != 59)
                applyStimulus("rand");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        op      = 4'd0;
        z       = 1'b0;
        mem_ack = 1'b0;
        #1;
        test_reset();
        test_ld_zero_wait();
        test_st_waits();
        test_jumps();
        test_back_to_back();
        test_reset_mid_fetch();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
